// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined CLA adder/subtractor.
package cla_pkg;

  localparam int unsigned GW = 4;

  function automatic int unsigned slice_w(input int unsigned w, input int unsigned stages);
    return w / stages;
  endfunction

  // Legal configuration: 4-bit groups, 1..W/GW stages, W splits into whole groups per stage
  function automatic bit cfg_ok(input int unsigned w, input int unsigned gw,
                                input int unsigned stages);
    return (gw == GW) && (stages >= 1) && (stages <= w / gw) && ((w % (stages * gw)) == 0);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational two-level carry-lookahead adder slice: 4-bit groups plus a group-lookahead tier.
module cla_slice
  import cla_pkg::*;
#(
  parameter int unsigned SW = 16
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co,
  output logic          c_msb
);

  localparam int unsigned NG = SW / GW;

  logic [SW-1:0] g;
  logic [SW-1:0] p;
  logic [SW-1:0] c;
  logic [NG-1:0] gg;
  logic [NG-1:0] pg;
  logic [NG:0]   gc;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate over each 4-bit group
  always_comb begin : group_gp
    gg = '0;
    pg = '1;
    for (int j = 0; j < int'(NG); j++) begin
      for (int i = 0; i < int'(GW); i++) begin
        gg[j] = g[j*GW+i] | (p[j*GW+i] & gg[j]);
        pg[j] = pg[j] & p[j*GW+i];
      end
    end
  end

  always_comb begin : group_lookahead
    gc    = '0;
    gc[0] = ci;
    for (int j = 0; j < int'(NG); j++) begin
      gc[j+1] = gg[j] | (pg[j] & gc[j]);
    end
  end

  // Bit carries inside each group start from that group's lookahead carry
  always_comb begin : bit_carry
    c = '0;
    for (int j = 0; j < int'(NG); j++) begin
      c[j*GW] = gc[j];
      for (int i = 1; i < int'(GW); i++) begin
        c[j*GW+i] = g[j*GW+i-1] | (p[j*GW+i-1] & c[j*GW+i-1]);
      end
    end
  end

  assign s     = p ^ c;
  assign co    = gc[NG];
  assign c_msb = c[SW-1];

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined valid/ready CLA adder/subtractor: one W/STAGES-bit slice resolved per stage,
// carry and unprocessed operand bits forwarded through stage registers.
module pipe_cla_addsub #(
  parameter int unsigned W      = 32,
  parameter int unsigned GW     = cla_pkg::GW,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned SW = cla_pkg::slice_w(W, STAGES);

  if (!cla_pkg::cfg_ok(W, GW, STAGES)) begin : g_bad_cfg
    $error("pipe_cla_addsub: need GW==4, 1<=STAGES<=W/GW and W a multiple of STAGES*GW");
  end

  logic [STAGES-1:0] vld;
  logic [STAGES:0]   rdy;

  // A stage can load when it is empty or its content moves on this cycle
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      rdy[k] = !vld[k] || rdy[k+1];
    end
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < STAGES - 1; k++) begin : g_st
    localparam int unsigned IW = W - k * SW;
    localparam int unsigned OW = W - (k + 1) * SW;
    localparam int unsigned DW = (k + 1) * SW;

    logic [IW-1:0] a_i, b_i;
    logic          c_i, v_i;
    logic [DW-1:0] r_i;
    logic [SW-1:0] s;
    logic          co, c_msb, unused_msb;
    logic          valid_q, valid_d, c_q, c_d;
    logic [OW-1:0] a_q, a_d, b_q, b_d;
    logic [DW-1:0] res_q, res_d;

    if (k == 0) begin : g_in
      assign a_i = a;
      assign b_i = b ^ {W{sub}};
      assign c_i = sub | cin;
      assign v_i = in_valid;
      assign r_i = s;
    end else begin : g_in
      assign a_i = g_st[k-1].a_q;
      assign b_i = g_st[k-1].b_q;
      assign c_i = g_st[k-1].c_q;
      assign v_i = g_st[k-1].valid_q;
      assign r_i = {s, g_st[k-1].res_q};
    end

    cla_slice #(.SW(SW)) u_slice (
      .a    (a_i[SW-1:0]),
      .b    (b_i[SW-1:0]),
      .ci   (c_i),
      .s    (s),
      .co   (co),
      .c_msb(c_msb)
    );

    assign unused_msb = c_msb;

    always_comb begin
      valid_d = valid_q;
      c_d     = c_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      if (rdy[k]) begin
        valid_d = v_i;
        if (v_i) begin
          c_d   = co;
          a_d   = a_i[IW-1:SW];
          b_d   = b_i[IW-1:SW];
          res_d = r_i;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        c_q     <= 1'b0;
        a_q     <= '0;
        b_q     <= '0;
        res_q   <= '0;
      end else begin
        valid_q <= valid_d;
        c_q     <= c_d;
        a_q     <= a_d;
        b_q     <= b_d;
        res_q   <= res_d;
      end
    end

    assign vld[k] = valid_q;
  end

  // Last stage: top slice plus flags, straight into the output registers
  logic [SW-1:0] fa, fb, fs;
  logic          fc, fv, fco, fmsb;
  logic [W-1:0]  fsum;

  if (STAGES == 1) begin : g_fin_in
    assign fa   = a;
    assign fb   = b ^ {W{sub}};
    assign fc   = sub | cin;
    assign fv   = in_valid;
    assign fsum = fs;
  end else begin : g_fin_in
    assign fa   = g_st[STAGES-2].a_q;
    assign fb   = g_st[STAGES-2].b_q;
    assign fc   = g_st[STAGES-2].c_q;
    assign fv   = g_st[STAGES-2].valid_q;
    assign fsum = {fs, g_st[STAGES-2].res_q};
  end

  cla_slice #(.SW(SW)) u_slice_last (
    .a    (fa),
    .b    (fb),
    .ci   (fc),
    .s    (fs),
    .co   (fco),
    .c_msb(fmsb)
  );

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] sum_q, sum_d;
  logic         cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    if (rdy[STAGES-1]) begin
      out_valid_d = fv;
      if (fv) begin
        sum_d  = fsum;
        cout_d = fco;
        ovf_d  = fco ^ fmsb;
        zero_d = (fsum == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign vld[STAGES-1] = out_valid_q;
  assign out_valid     = out_valid_q;
  assign sum           = sum_q;
  assign cout          = cout_q;
  assign ovf           = ovf_q;
  assign zero          = zero_q;

endmodule
